// File: rtl/serial_sub_ctrl.sv
// Bit-serial WIDTH-bit subtractor: diff = a - b - bin, LSB first, one bit per clock,
// time-sharing a single 1-bit full_subtractor cell with a registered borrow loop.

module full_subtractor (
   input  logic a,
   input  logic b,
   input  logic bin,
   output logic diff,
   output logic b_out
);
   assign diff  = a ^ b ^ bin;
   assign b_out = (~a & b) | (~(a ^ b) & bin);
endmodule

module serial_sub_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             bout
);
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state_reg, state_next;
   logic [WIDTH-1:0] a_sr_reg, b_sr_reg, res_sr_reg, diff_reg;
   logic             borrow_reg, bout_reg;
   logic [CW-1:0]    cnt_reg;
   logic             cell_diff, cell_bout, last_bit;
   logic [WIDTH-1:0] res_shifted;

   full_subtractor u_cell (
      .a    (a_sr_reg[0]),
      .b    (b_sr_reg[0]),
      .bin  (borrow_reg),
      .diff (cell_diff),
      .b_out(cell_bout)
   );

   assign last_bit    = (cnt_reg == CW'(WIDTH - 1));
   assign res_shifted = {cell_diff, res_sr_reg[WIDTH-1:1]};

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (start) state_next = RUN;
         RUN:     if (last_bit) state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_reg <= IDLE;
      else        state_reg <= state_next;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_sr_reg   <= '0;
         b_sr_reg   <= '0;
         res_sr_reg <= '0;
         diff_reg   <= '0;
         borrow_reg <= 1'b0;
         bout_reg   <= 1'b0;
         cnt_reg    <= '0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (start) begin
                  a_sr_reg   <= a;
                  b_sr_reg   <= b;
                  borrow_reg <= bin;
                  cnt_reg    <= '0;
               end
            end
            RUN: begin
               res_sr_reg <= res_shifted;
               borrow_reg <= cell_bout;
               a_sr_reg   <= a_sr_reg >> 1;
               b_sr_reg   <= b_sr_reg >> 1;
               // The final bit is folded straight into the visible result so it is valid with done.
               if (last_bit) begin
                  diff_reg <= res_shifted;
                  bout_reg <= cell_bout;
               end else begin
                  cnt_reg <= cnt_reg + CW'(1);
               end
            end
            default: ;
         endcase
      end
   end

   assign busy = (state_reg == RUN);
   assign done = (state_reg == DONE);
   assign diff = diff_reg;
   assign bout = bout_reg;
endmodule
